// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive-side bit/byte timer.
package usb_rx_pkg;

    localparam int unsigned USB_CLKS_PER_BIT  = 8;
    localparam int unsigned USB_STUFF_LIMIT   = 6;
    localparam int unsigned USB_BITS_PER_BYTE = 8;
    localparam int unsigned USB_MAX_BYTES     = 17;

    typedef logic [4:0] byte_cnt_t;
    typedef logic [2:0] bit_cnt_t;
    typedef logic [2:0] ones_cnt_t;

endpackage

// File: rtl/usb_rx_bit_phase.sv
// Bit-phase counter for the USB receiver. Runs freely inside a bit time and is
// resynchronised by decoded-line edges; raises sample once per bit at SAMPLE_POINT.
module usb_rx_bit_phase
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_POINT = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic receiving_i,
    input  logic d_edge_i,
    output logic sample_o
);

    localparam int unsigned PhaseW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [PhaseW-1:0] phase_q, phase_d;

    // Next phase: idle holds 0; an edge marks phase 0, so the following cycle is phase 1.
    always_comb begin
        phase_d = phase_q;
        if (!receiving_i) begin
            phase_d = '0;
        end else if (d_edge_i) begin
            phase_d = PhaseW'(1);
        end else if (phase_q == PhaseW'(CLKS_PER_BIT - 1)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    // Phase register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign sample_o = receiving_i && (phase_q == PhaseW'(SAMPLE_POINT));

endmodule

// File: rtl/usb_timer_rx.sv
// USB receive bit/byte timer: recovers mid-bit sample strobes, drops stuffed bits,
// counts bits into bytes and bytes into a packet, and flags alignment/overflow errors.
// Optional feature macro: USB_RX_STUFF_ERR_EN (stuff bit seen as 1 pulses stuff_err_o).
module usb_timer_rx
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int unsigned SAMPLE_POINT = 3,
    parameter int unsigned MAX_BYTES    = USB_MAX_BYTES
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      receiving_i,
    input  logic      d_edge_i,
    input  logic      d_orig_i,
    input  logic      eop_i,
    output logic      shift_enable_o,
    output logic      byte_received_o,
    output byte_cnt_t byte_count_o,
    output logic      rx_overflow_o,
    output logic      align_err_o,
    output logic      stuff_err_o
);

    logic      sample;
    logic      stuff_bit;
    ones_cnt_t ones_q, ones_d;
    bit_cnt_t  bit_q, bit_d;
    byte_cnt_t byte_cnt_q, byte_cnt_d;
    logic      overflow_q, overflow_d;
    logic      byte_rx_q, byte_rx_d;
    logic      align_q, align_d;

    usb_rx_bit_phase #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_POINT (SAMPLE_POINT)
    ) u_phase (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .receiving_i (receiving_i),
        .d_edge_i    (d_edge_i),
        .sample_o    (sample)
    );

    // After six consecutive ones the next sampled bit is a stuff bit and is dropped.
    assign stuff_bit      = sample && (ones_q == ones_cnt_t'(USB_STUFF_LIMIT));
    assign shift_enable_o = sample && !(ones_q == ones_cnt_t'(USB_STUFF_LIMIT));

    // Next-state for destuffing, bit/byte counters and error flags.
    always_comb begin
        ones_d     = ones_q;
        bit_d      = bit_q;
        byte_cnt_d = byte_cnt_q;
        overflow_d = overflow_q;
        byte_rx_d  = 1'b0;

        if (stuff_bit) begin
            ones_d = '0;
        end else if (shift_enable_o) begin
            ones_d = d_orig_i ? ones_q + 1'b1 : '0;
        end

        if (shift_enable_o) begin
            if (bit_q == bit_cnt_t'(USB_BITS_PER_BYTE - 1)) begin
                bit_d     = '0;
                byte_rx_d = 1'b1;
            end else begin
                bit_d = bit_q + 1'b1;
            end
        end

        if (byte_rx_q) begin
            if (byte_cnt_q < byte_cnt_t'(MAX_BYTES)) begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        // Uses the post-update bit count so eop on the 8th bit is a clean end.
        align_d = eop_i && receiving_i && (bit_d != '0);

        // Leaving the packet body wipes timing state; a pending byte pulse still fires.
        if (!receiving_i) begin
            ones_d     = '0;
            bit_d      = '0;
            byte_cnt_d = '0;
            overflow_d = 1'b0;
        end
    end

    // State and registered pulse outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ones_q     <= '0;
            bit_q      <= '0;
            byte_cnt_q <= '0;
            overflow_q <= 1'b0;
            byte_rx_q  <= 1'b0;
            align_q    <= 1'b0;
        end else begin
            ones_q     <= ones_d;
            bit_q      <= bit_d;
            byte_cnt_q <= byte_cnt_d;
            overflow_q <= overflow_d;
            byte_rx_q  <= byte_rx_d;
            align_q    <= align_d;
        end
    end

    assign byte_received_o = byte_rx_q;
    assign byte_count_o    = byte_cnt_q;
    assign rx_overflow_o   = overflow_q;
    assign align_err_o     = align_q;

`ifdef USB_RX_STUFF_ERR_EN
    logic stuff_err_q;

    // A stuff bit must be 0; a 1 there is a stuffing violation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stuff_err_q <= 1'b0;
        end else begin
            stuff_err_q <= stuff_bit && d_orig_i;
        end
    end

    assign stuff_err_o = stuff_err_q;
`else
    assign stuff_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_usb_timer_rx.sv
// Self-checking bench for usb_timer_rx. Expected pulse cycles are queued when stimulus
// is applied and popped by a monitor when the DUT pulses.
module tb_usb_timer_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       receiving = 1'b0;
    logic       d_edge = 1'b0;
    logic       d_orig = 1'b0;
    logic       eop = 1'b0;
    logic       shift_enable;
    logic       byte_received;
    logic [4:0] byte_count;
    logic       rx_overflow;
    logic       align_err;
    logic       stuff_err;

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int mon_e;
    int se_q[$];
    int br_q[$];
    int ae_q[$];
    int st_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    usb_timer_rx #(
        .CLKS_PER_BIT (8),
        .SAMPLE_POINT (3),
        .MAX_BYTES    (17)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .receiving_i     (receiving),
        .d_edge_i        (d_edge),
        .d_orig_i        (d_orig),
        .eop_i           (eop),
        .shift_enable_o  (shift_enable),
        .byte_received_o (byte_received),
        .byte_count_o    (byte_count),
        .rx_overflow_o   (rx_overflow),
        .align_err_o     (align_err),
        .stuff_err_o     (stuff_err)
    );

    // Scoreboard monitor: every pulse must match the head of its expected-cycle queue.
    always @(negedge clk) begin
        if (shift_enable === 1'b1) begin
            total++;
            if (se_q.size() == 0) begin
                $display("FAIL shift_enable: pulse at cycle %0d, none expected", cyc);
            end else begin
                mon_e = se_q.pop_front();
                if (mon_e != cyc) $display("FAIL shift_enable: got cycle %0d, want %0d", cyc, mon_e);
                else passed++;
            end
        end
        if (byte_received === 1'b1) begin
            total++;
            if (br_q.size() == 0) begin
                $display("FAIL byte_received: pulse at cycle %0d, none expected", cyc);
            end else begin
                mon_e = br_q.pop_front();
                if (mon_e != cyc) $display("FAIL byte_received: got cycle %0d, want %0d", cyc, mon_e);
                else passed++;
            end
        end
        if (align_err === 1'b1) begin
            total++;
            if (ae_q.size() == 0) begin
                $display("FAIL align_err: pulse at cycle %0d, none expected", cyc);
            end else begin
                mon_e = ae_q.pop_front();
                if (mon_e != cyc) $display("FAIL align_err: got cycle %0d, want %0d", cyc, mon_e);
                else passed++;
            end
        end
        if (stuff_err === 1'b1) begin
            total++;
            if (st_q.size() == 0) begin
                $display("FAIL stuff_err: pulse at cycle %0d, none expected", cyc);
            end else begin
                mon_e = st_q.pop_front();
                if (mon_e != cyc) $display("FAIL stuff_err: got cycle %0d, want %0d", cyc, mon_e);
                else passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        receiving = 1'b0;
        tick();
        tick();
        @(negedge clk);
        total++;
        if ({shift_enable, byte_received, byte_count, rx_overflow, align_err, stuff_err} !== 10'b0)
            $display("FAIL reset_outputs: got %b, want 0", {shift_enable, byte_received,
                     byte_count, rx_overflow, align_err, stuff_err});
        else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int t0;
        t0 = cyc;
        receiving = 1'b1;
        d_orig = 1'b0;
        for (int k = 0; k < 8; k++) se_q.push_back(t0 + 3 + 8 * k);
        br_q.push_back(t0 + 60);
        run_to(t0 + 61);
        @(negedge clk);
        total++;
        if (byte_count !== 5'd1) $display("FAIL basic_count: got %0d, want 1", byte_count);
        else passed++;
        total++;
        if (rx_overflow !== 1'b0) $display("FAIL basic_overflow: got %b, want 0", rx_overflow);
        else passed++;
        run_to(t0 + 62);
        receiving = 1'b0;
        run_to(t0 + 63);
        @(negedge clk);
        total++;
        if (byte_count !== 5'd0) $display("FAIL basic_count_clear: got %0d, want 0", byte_count);
        else passed++;
        total++;
        if (se_q.size() + br_q.size() != 0)
            $display("FAIL basic_missing: got %0d pending pulses, want 0", se_q.size() + br_q.size());
        else passed++;
    endtask

    task automatic test_resync();
        int t0;
        int t1;
        t0 = cyc;
        receiving = 1'b1;
        se_q.push_back(t0 + 3);
        se_q.push_back(t0 + 8);
        se_q.push_back(t0 + 16);
        run_to(t0 + 5);
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        run_to(t0 + 20);
        receiving = 1'b0;
        tick();
        // Edge while idle must not disturb the phase.
        t1 = cyc;
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        receiving = 1'b1;
        se_q.push_back(t1 + 4);
        run_to(t1 + 6);
        receiving = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (se_q.size() != 0) $display("FAIL resync_missing: got %0d pending, want 0", se_q.size());
        else passed++;
    endtask

    task automatic test_stuff(input bit stuff_val);
        int t0;
        t0 = cyc;
        receiving = 1'b1;
        for (int k = 0; k < 9; k++) if (k != 6) se_q.push_back(t0 + 3 + 8 * k);
        br_q.push_back(t0 + 68);
`ifdef USB_RX_STUFF_ERR_EN
        if (stuff_val) st_q.push_back(t0 + 52);
`endif
        while (cyc < t0 + 69) begin
            if (cyc - t0 < 48) d_orig = 1'b1;
            else if (cyc - t0 < 56) d_orig = stuff_val;
            else d_orig = 1'b0;
            tick();
        end
        receiving = 1'b0;
        d_orig = 1'b0;
        @(negedge clk);
        total++;
        if (byte_count !== 5'd1) $display("FAIL stuff_count: got %0d, want 1", byte_count);
        else passed++;
        tick();
        @(negedge clk);
        total++;
        if (se_q.size() + br_q.size() + st_q.size() != 0)
            $display("FAIL stuff_missing: got %0d pending, want 0",
                     se_q.size() + br_q.size() + st_q.size());
        else passed++;
    endtask

    task automatic test_overflow();
        int t0;
        t0 = cyc;
        receiving = 1'b1;
        d_orig = 1'b0;
        for (int k = 0; k < 144; k++) se_q.push_back(t0 + 3 + 8 * k);
        for (int j = 0; j < 18; j++) br_q.push_back(t0 + 60 + 64 * j);
        run_to(t0 + 1085);
        @(negedge clk);
        total++;
        if ({byte_count, rx_overflow} !== {5'd17, 1'b0})
            $display("FAIL ovf_17th: got count %0d ovf %b, want 17 0", byte_count, rx_overflow);
        else passed++;
        run_to(t0 + 1149);
        @(negedge clk);
        total++;
        if ({byte_count, rx_overflow} !== {5'd17, 1'b1})
            $display("FAIL ovf_18th: got count %0d ovf %b, want 17 1", byte_count, rx_overflow);
        else passed++;
        run_to(t0 + 1150);
        receiving = 1'b0;
        run_to(t0 + 1151);
        @(negedge clk);
        total++;
        if ({byte_count, rx_overflow} !== {5'd0, 1'b0})
            $display("FAIL ovf_clear: got count %0d ovf %b, want 0 0", byte_count, rx_overflow);
        else passed++;
        total++;
        if (se_q.size() + br_q.size() != 0)
            $display("FAIL ovf_missing: got %0d pending, want 0", se_q.size() + br_q.size());
        else passed++;
    endtask

    task automatic test_align();
        int t0;
        int t1;
        t0 = cyc;
        receiving = 1'b1;
        for (int k = 0; k < 3; k++) se_q.push_back(t0 + 3 + 8 * k);
        ae_q.push_back(t0 + 21);
        run_to(t0 + 20);
        eop = 1'b1;
        tick();
        eop = 1'b0;
        receiving = 1'b0;
        tick();
        t1 = cyc;
        receiving = 1'b1;
        for (int k = 0; k < 8; k++) se_q.push_back(t1 + 3 + 8 * k);
        br_q.push_back(t1 + 60);
        run_to(t1 + 59);
        eop = 1'b1;
        tick();
        eop = 1'b0;
        receiving = 1'b0;
        @(negedge clk);
        total++;
        if (align_err !== 1'b0) $display("FAIL align_clean_eop: got %b, want 0", align_err);
        else passed++;
        tick();
        @(negedge clk);
        total++;
        if (se_q.size() + br_q.size() + ae_q.size() != 0)
            $display("FAIL align_missing: got %0d pending, want 0",
                     se_q.size() + br_q.size() + ae_q.size());
        else passed++;
    endtask

    task automatic test_rst_mid_byte();
        int t0;
        t0 = cyc;
        receiving = 1'b1;
        for (int k = 0; k < 13; k++) se_q.push_back(t0 + 3 + 8 * k);
        br_q.push_back(t0 + 60);
        run_to(t0 + 99);
        rst = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({shift_enable, byte_received, byte_count, rx_overflow, align_err, stuff_err} !== 10'b0)
            $display("FAIL rst_mid_outputs: got %b, want 0", {shift_enable, byte_received,
                     byte_count, rx_overflow, align_err, stuff_err});
        else passed++;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) se_q.push_back(t0 + 104 + 8 * k);
        br_q.push_back(t0 + 161);
        run_to(t0 + 162);
        @(negedge clk);
        total++;
        if (byte_count !== 5'd1) $display("FAIL rst_restart_count: got %0d, want 1", byte_count);
        else passed++;
        receiving = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (se_q.size() + br_q.size() != 0)
            $display("FAIL rst_missing: got %0d pending, want 0", se_q.size() + br_q.size());
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_stuff(1'b0);
        test_stuff(1'b1);
        test_overflow();
        test_align();
        test_rst_mid_byte();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
